memory_responder: RTL and testbench

Memory-side responder for the basic processor's sequencer bus. It holds the MAR and MDR and a single-port RAM of 2^(WORD_W-OP_W) words. It services the sequencer's CS/R_NW read and write cycles with the single-cycle timing the sequencer requires. It also accepts a four-phase program-load handshake that writes words into RAM only in cycles the processor leaves idle.

---
 rtl/memory_pkg.sv | 14 +
 rtl/mem_array.sv | 26 ++
 rtl/memory_responder.sv | 110 +++++++++++
 tb/tb_memory_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and helpers for the memory responder and its RAM.
package memory_pkg;

  typedef enum logic [1:0] {
    L_IDLE,
    L_WAIT,
    L_ACK
  } loader_state_t;

  function automatic int unsigned addr_w(input int unsigned word_w, input int unsigned op_w);
    return word_w - op_w;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port RAM with synchronous write and a read port that the MDR register captures.
module mem_array #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned Depth = 1 << ADDR_W;

  // Contents are deliberately not reset so a loaded program survives n_reset.
  logic [WORD_W-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_responder.sv
// Memory side of the sequencer bus: MAR/MDR, RAM, and an idle-cycle program loader.
module memory_responder
  import memory_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned OP_W   = 3,
  localparam int unsigned ADDR_W = addr_w(WORD_W, OP_W)
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] bus_in,
  input  logic              load_MAR,
  input  logic              load_MDR,
  input  logic              MDR_bus,
  input  logic              CS,
  input  logic              R_NW,
  output logic [WORD_W-1:0] mdr_out,
  output logic              mdr_drive,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  output logic              ld_ack
);

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  loader_state_t     state_q, state_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic              proc_read;
  logic              proc_write;
  logic              ld_write;

  assign proc_read  = CS && R_NW;
  assign proc_write = CS && !R_NW;
  // The processor owns the RAM port whenever CS is high; the loader only gets idle cycles.
  assign ld_write   = (state_q == L_WAIT) && !CS;

  always_comb begin
    ram_we    = proc_write || ld_write;
    ram_addr  = mar_q;
    ram_wdata = mdr_q;
    if (!CS) begin
      ram_addr  = ld_addr;
      ram_wdata = ld_data;
    end
  end

  mem_array #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    mar_d = mar_q;
    mdr_d = mdr_q;
    if (load_MAR) begin
      mar_d = bus_in[ADDR_W-1:0];
    end
    // A read in the same cycle as load_MDR wins.
    if (proc_read) begin
      mdr_d = ram_rdata;
    end else if (load_MDR) begin
      mdr_d = bus_in;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_ack  = 1'b0;
    unique case (state_q)
      L_IDLE: begin
        if (ld_req) state_d = L_WAIT;
      end
      L_WAIT: begin
        if (!CS) state_d = L_ACK;
      end
      L_ACK: begin
        ld_ack = 1'b1;
        if (!ld_req) state_d = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mar_q   <= '0;
      mdr_q   <= '0;
      state_q <= L_IDLE;
    end else begin
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      state_q <= state_d;
    end
  end

  assign mdr_out   = mdr_q;
  assign mdr_drive = MDR_bus;

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder.
module tb_memory_responder;

  logic       clock;
  logic       n_reset;
  logic [7:0] bus_in;
  logic       load_MAR;
  logic       load_MDR;
  logic       MDR_bus;
  logic       CS;
  logic       R_NW;
  logic [7:0] mdr_out;
  logic       mdr_drive;
  logic       ld_req;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_ack;

  int n_pass  = 0;
  int n_total = 0;

  memory_responder #(
    .WORD_W (8),
    .OP_W   (3)
  ) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .bus_in    (bus_in),
    .load_MAR  (load_MAR),
    .load_MDR  (load_MDR),
    .MDR_bus   (MDR_bus),
    .CS        (CS),
    .R_NW      (R_NW),
    .mdr_out   (mdr_out),
    .mdr_drive (mdr_drive),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ack    (ld_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_mar(input logic [7:0] v);
    bus_in   = v;
    load_MAR = 1'b1;
    tick();
    load_MAR = 1'b0;
  endtask

  task automatic set_mdr(input logic [7:0] v);
    bus_in   = v;
    load_MDR = 1'b1;
    tick();
    load_MDR = 1'b0;
  endtask

  task automatic proc_read();
    CS   = 1'b1;
    R_NW = 1'b1;
    tick();
    CS   = 1'b0;
  endtask

  task automatic proc_write();
    CS   = 1'b1;
    R_NW = 1'b0;
    tick();
    CS   = 1'b0;
    R_NW = 1'b1;
  endtask

  // Full four-phase handshake with CS idle; lat returns cycles from request to ack.
  task automatic do_load(input logic [4:0] a, input logic [7:0] d, output int lat);
    ld_addr = a;
    ld_data = d;
    ld_req  = 1'b1;
    lat     = 0;
    while (!ld_ack && lat < 20) begin
      tick();
      lat++;
    end
    check("ld_ack_rise", {31'd0, ld_ack}, 32'd1);
    ld_req = 1'b0;
    tick();
    check("ld_ack_fall", {31'd0, ld_ack}, 32'd0);
  endtask

  int lat;

  initial begin
    n_reset  = 1'b0;
    bus_in   = '0;
    load_MAR = 1'b0;
    load_MDR = 1'b0;
    MDR_bus  = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b1;
    ld_req   = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    tick();
    tick();

    // Reset state; mdr_drive follows MDR_bus even in reset
    check("rst_mdr", {24'd0, mdr_out}, 32'h0);
    check("rst_ack", {31'd0, ld_ack}, 32'h0);
    MDR_bus = 1'b1;
    #1;
    check("rst_drive_hi", {31'd0, mdr_drive}, 32'h1);
    MDR_bus = 1'b0;
    #1;
    check("rst_drive_lo", {31'd0, mdr_drive}, 32'h0);
    n_reset = 1'b1;
    tick();

    // Preload via loader, best-case latency, then processor read
    do_load(5'd5, 8'h2A, lat);
    check("ld_latency", lat, 32'd2);
    set_mar(8'd5);
    proc_read();
    check("read_5", {24'd0, mdr_out}, 32'h2A);
    MDR_bus = 1'b1;
    #1;
    check("drive_follow", {31'd0, mdr_drive}, 32'h1);
    MDR_bus = 1'b0;

    // Write then read
    set_mdr(8'hC3);
    set_mar(8'd17);
    proc_write();
    set_mdr(8'h00);
    proc_read();
    check("wr_rd_17", {24'd0, mdr_out}, 32'hC3);

    // Read in the cycle right after a write, with load_MDR competing
    set_mdr(8'h3C);
    set_mar(8'd18);
    proc_write();
    bus_in   = 8'h00;
    load_MDR = 1'b1;
    proc_read();
    load_MDR = 1'b0;
    check("wr_rd_b2b", {24'd0, mdr_out}, 32'h3C);

    // Loader contention
    do_load(5'd3, 8'h01, lat);
    set_mar(8'd3);
    ld_addr = 5'd3;
    ld_data = 8'h55;
    ld_req  = 1'b1;
    CS      = 1'b1;
    R_NW    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cont_ack_low", {31'd0, ld_ack}, 32'h0);
      check("cont_no_write", {24'd0, mdr_out}, 32'h01);
    end
    CS = 1'b0;
    tick();
    check("cont_ack_rise", {31'd0, ld_ack}, 32'h1);
    tick();
    check("cont_ack_hold", {31'd0, ld_ack}, 32'h1);
    ld_req = 1'b0;
    tick();
    check("cont_ack_fall", {31'd0, ld_ack}, 32'h0);
    proc_read();
    check("cont_written", {24'd0, mdr_out}, 32'h55);

    // load_MAR with CS: access uses old MAR
    set_mar(8'd5);
    bus_in   = 8'd17;
    load_MAR = 1'b1;
    proc_read();
    load_MAR = 1'b0;
    check("old_mar", {24'd0, mdr_out}, 32'h2A);
    proc_read();
    check("new_mar", {24'd0, mdr_out}, 32'hC3);

    // load_MDR with CS read: read wins
    do_load(5'd9, 8'h99, lat);
    set_mar(8'd9);
    bus_in   = 8'h11;
    load_MDR = 1'b1;
    proc_read();
    load_MDR = 1'b0;
    check("read_wins", {24'd0, mdr_out}, 32'h99);

    // Reset mid-handshake
    do_load(5'd0, 8'h77, lat);
    ld_addr = 5'd3;
    ld_data = 8'hEE;
    ld_req  = 1'b1;
    CS      = 1'b1;
    R_NW    = 1'b1;
    tick();
    tick();
    n_reset = 1'b0;
    #1;
    check("rst_mid_ack", {31'd0, ld_ack}, 32'h0);
    check("rst_mid_mdr", {24'd0, mdr_out}, 32'h0);
    CS     = 1'b0;
    ld_req = 1'b0;
    tick();
    n_reset = 1'b1;
    tick();
    tick();
    check("rst_mid_ack2", {31'd0, ld_ack}, 32'h0);
    proc_read();
    check("rst_mar_zero", {24'd0, mdr_out}, 32'h77);
    set_mar(8'd3);
    proc_read();
    check("rst_target_kept", {24'd0, mdr_out}, 32'h55);
    set_mar(8'd5);
    proc_read();
    check("rst_other_kept", {24'd0, mdr_out}, 32'h2A);

    // Address wrap
    do_load(5'd31, 8'hB7, lat);
    set_mar(8'hFF);
    proc_read();
    check("wrap_31", {24'd0, mdr_out}, 32'hB7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
